// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the TPIU-style trace transmitter.
//   SYNC_HI_WORD / SYNC_LO_WORD : the two halves of the 32-bit sync (ff ff ff 7f)
//   wsel_t                      : latched bus width (1, 2 or 4 bits per edge)
//   state_t                     : control FSM states (word currently on the bus)
//   decode_width / last_cycle   : width-pin decode and trace cycles per word - 1
package trace_pkg;

  localparam logic [15:0] SYNC_HI_WORD = 16'hffff;
  localparam logic [15:0] SYNC_LO_WORD = 16'h7fff;

  // Encodings of the width pins
  localparam logic [1:0] WIDTH_PIN_2BIT = 2'd2;
  localparam logic [1:0] WIDTH_PIN_4BIT = 2'd3;

  typedef enum logic [1:0] {
    W1 = 2'd0,
    W2 = 2'd1,
    W4 = 2'd2
  } wsel_t;

  typedef enum logic [1:0] {
    ST_SYNC_HI = 2'd0,
    ST_SYNC_LO = 2'd1,
    ST_DATA    = 2'd2
  } state_t;

  // Pins 0 and 1 both select the 1-bit bus
  function automatic wsel_t decode_width(input logic [1:0] width);
    case (width)
      WIDTH_PIN_4BIT: return W4;
      WIDTH_PIN_2BIT: return W2;
      default:        return W1;
    endcase
  endfunction

  // Trace cycles per word minus one: 16 bits / (2 * w)
  function automatic logic [2:0] last_cycle(input wsel_t w);
    case (w)
      W4:      return 3'd1;
      W2:      return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/trace_tx_ser.sv
// trace_tx_ser: 16-bit DDR serialiser for the trace port.
//   clk, rst         : system clock, asynchronous active-low reset
//   tick             : one-cycle strobe on the clk edge that enters ph0
//   width            : width pins, sampled only when a new word is loaded
//   load_word        : next word, taken when word_done is high
//   word_done        : current word fully shifted out at this tick
//   douta, doutb     : data for the trace-clock rising / falling edge
module trace_tx_ser
  import trace_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [1:0]  width,
  input  logic [15:0] load_word,
  output logic        word_done,
  output logic [3:0]  douta,
  output logic [3:0]  doutb
);

  logic [15:0] sr_reg;
  wsel_t       w_reg;
  logic [2:0]  cnt_reg;
  logic [3:0]  douta_reg;
  logic [3:0]  doutb_reg;

  logic [15:0] src;
  logic [15:0] shifted;
  wsel_t       cur_w;
  logic [3:0]  a_next;
  logic [3:0]  b_next;

  // A zero count at a tick means the previous word is finished (also true
  // straight out of reset, so the first tick loads the first sync word).
  assign word_done = tick && (cnt_reg == 3'd0);

  // A new word is serialised directly from load_word on its first trace
  // cycle, so there is no dead trace cycle between words.
  always_comb begin
    src     = word_done ? load_word : sr_reg;
    cur_w   = word_done ? decode_width(width) : w_reg;
    a_next  = 4'h0;
    b_next  = 4'h0;
    shifted = src;
    case (cur_w)
      W4: begin
        a_next  = src[3:0];
        b_next  = src[7:4];
        shifted = {8'h00, src[15:8]};
      end
      W2: begin
        a_next  = {2'b00, src[1:0]};
        b_next  = {2'b00, src[3:2]};
        shifted = {4'h0, src[15:4]};
      end
      default: begin
        a_next  = {3'b000, src[0]};
        b_next  = {3'b000, src[1]};
        shifted = {2'b00, src[15:2]};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_reg    <= 16'h0000;
      w_reg     <= W1;
      cnt_reg   <= 3'd0;
      douta_reg <= 4'h0;
      doutb_reg <= 4'h0;
    end else if (tick) begin
      douta_reg <= a_next;
      doutb_reg <= b_next;
      sr_reg    <= shifted;
      if (word_done) begin
        w_reg   <= cur_w;
        cnt_reg <= last_cycle(cur_w);
      end else begin
        cnt_reg <= cnt_reg - 3'd1;
      end
    end
  end

  assign douta = douta_reg;
  assign doutb = doutb_reg;

endmodule

// File: rtl/trace_tx.sv
// trace_tx: transmit side of a TPIU-style parallel trace port.
// Serialises 16-bit words (low byte first) onto a 1/2/4-bit DDR bus with a
// clk/4 trace clock, inserting the ff ff ff 7f sync after reset, on request,
// every SYNC_INTERVAL data words, and whenever there is nothing to send.
//   clk, rst        : system clock, asynchronous active-low reset
//   width           : 0,1 = 1 bit, 2 = 2 bit, 3 = 4 bit (latched per word)
//   PacketWd        : word to send
//   WdAvail/WdReady : upstream handshake, one-word holding register
//   syncReq         : pulse requesting a sync at the next word boundary
//   traceDouta/b    : data for trace-clock rising / falling edge
//   traceClkout     : generated trace clock
//   sending         : the word on the bus is data, not sync
module trace_tx
  import trace_pkg::*;
#(
  parameter int unsigned SYNC_INTERVAL = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  width,
  input  logic [15:0] PacketWd,
  input  logic        WdAvail,
  output logic        WdReady,
  input  logic        syncReq,
  output logic [3:0]  traceDouta,
  output logic [3:0]  traceDoutb,
  output logic        traceClkout,
  output logic        sending
);

  localparam logic [15:0] INTERVAL = 16'(SYNC_INTERVAL);
  localparam bit          PERIODIC = (SYNC_INTERVAL != 0);

  state_t      state_reg, state_next;
  logic [1:0]  ph_reg;
  logic [1:0]  ph_next;
  logic        clk_out_reg;
  logic        primed_reg;
  logic        pending_reg, pending_next;
  logic [15:0] word_cnt_reg, word_cnt_next;
  logic        hold_full_reg, hold_full_next;
  logic [15:0] hold_data_reg;
  logic        ready_reg;
  logic        sending_reg;

  logic        tick;
  logic        word_done;
  logic [15:0] load_word;
  logic        start_sync;
  logic        sync_done;
  logic        take_hold;
  logic        xfer;
  logic [15:0] cnt_base;
  logic [15:0] cnt_inc;
  logic        interval_hit;

  assign ph_next = ph_reg + 2'd1;
  assign tick    = (ph_reg == 2'd3);
  assign xfer    = WdAvail && ready_reg;

  trace_tx_ser u_ser (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .width     (width),
    .load_word (load_word),
    .word_done (word_done),
    .douta     (traceDouta),
    .doutb     (traceDoutb)
  );

  // Next-state / word selection. primed_reg distinguishes the reset-time
  // SYNC_HI (nothing on the bus yet) from a SYNC_HI word actually sent.
  always_comb begin
    state_next = state_reg;
    load_word  = SYNC_HI_WORD;
    start_sync = 1'b0;
    sync_done  = 1'b0;
    take_hold  = 1'b0;
    if (word_done) begin
      if (primed_reg && state_reg == ST_SYNC_HI) begin
        load_word  = SYNC_LO_WORD;
        state_next = ST_SYNC_LO;
      end else begin
        sync_done = primed_reg && (state_reg == ST_SYNC_LO);
        if (pending_reg) begin
          start_sync = 1'b1;
          state_next = ST_SYNC_HI;
        end else if (hold_full_reg) begin
          load_word  = hold_data_reg;
          take_hold  = 1'b1;
          state_next = ST_DATA;
        end else begin
          start_sync = 1'b1;
          state_next = ST_SYNC_HI;
        end
      end
    end
  end

  // Sync bookkeeping. A sync request seen while a sync pair is on the bus is
  // absorbed by it; clearing pending at sync start gives the same effect for
  // a request arriving on the very boundary that starts a sync.
  always_comb begin
    cnt_base      = sync_done ? 16'h0000 : word_cnt_reg;
    cnt_inc       = cnt_base + 16'h0001;
    word_cnt_next = take_hold ? cnt_inc : cnt_base;
    interval_hit  = PERIODIC && take_hold && (cnt_inc == INTERVAL);

    pending_next = pending_reg;
    if (start_sync) begin
      pending_next = 1'b0;
    end else if ((syncReq && state_reg == ST_DATA) || interval_hit) begin
      pending_next = 1'b1;
    end

    hold_full_next = hold_full_reg;
    if (xfer) begin
      hold_full_next = 1'b1;
    end else if (take_hold) begin
      hold_full_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_SYNC_HI;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_reg        <= 2'd0;
      clk_out_reg   <= 1'b0;
      primed_reg    <= 1'b0;
      pending_reg   <= 1'b1;
      word_cnt_reg  <= 16'h0000;
      hold_full_reg <= 1'b0;
      hold_data_reg <= 16'h0000;
      ready_reg     <= 1'b0;
      sending_reg   <= 1'b0;
    end else begin
      ph_reg        <= ph_next;
      // Registered so the trace clock is glitch-free: high in ph1 and ph2
      clk_out_reg   <= ph_next[0] ^ ph_next[1];
      pending_reg   <= pending_next;
      word_cnt_reg  <= word_cnt_next;
      hold_full_reg <= hold_full_next;
      ready_reg     <= !hold_full_next;
      if (xfer) begin
        hold_data_reg <= PacketWd;
      end
      if (word_done) begin
        primed_reg  <= 1'b1;
        sending_reg <= take_hold;
      end
    end
  end

  assign WdReady     = ready_reg;
  assign traceClkout = clk_out_reg;
  assign sending     = sending_reg;

endmodule

// File: tb/tb_trace_tx.sv
// tb_trace_tx: directed, table-driven bench for trace_tx (SYNC_INTERVAL = 2).
// A monitor captures one (A, B, sending) record per trace-clock rise.
module tb_trace_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  width = 2'd3;
  logic [15:0] PacketWd = 16'h0000;
  logic        WdAvail = 1'b0;
  logic        syncReq = 1'b0;
  logic        WdReady;
  logic [3:0]  traceDouta;
  logic [3:0]  traceDoutb;
  logic        traceClkout;
  logic        sending;

  localparam logic [16:0] SHI = 17'h0ffff;
  localparam logic [16:0] SLO = 17'h07fff;

  always #5 clk = ~clk;

  trace_tx #(.SYNC_INTERVAL(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .width       (width),
    .PacketWd    (PacketWd),
    .WdAvail     (WdAvail),
    .WdReady     (WdReady),
    .syncReq     (syncReq),
    .traceDouta  (traceDouta),
    .traceDoutb  (traceDoutb),
    .traceClkout (traceClkout),
    .sending     (sending)
  );

  typedef struct packed {
    logic [3:0]  a;
    logic [3:0]  b;
    logic        snd;
    logic [31:0] stamp;
  } pair_t;

  typedef struct packed {
    logic [1:0]  width;
    logic [15:0] word;
    logic [3:0]  n;
    logic [31:0] a_seq;   // nibble i = A of data trace cycle i
    logic [31:0] b_seq;   // nibble i = B of data trace cycle i
  } vec_t;

  pair_t       cap_q[$];
  int          cyc = 0;
  logic        mon_prev = 1'b0;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[7];
  logic [15:0] stream_words[5];
  logic [16:0] exp_w[13];

  // Monitor: one record per trace-clock rise, sampled on the falling clk edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        mon_prev = 1'b0;
      end else begin
        if (traceClkout && !mon_prev)
          cap_q.push_back('{traceDouta, traceDoutb, sending, 32'(cyc)});
        mon_prev = traceClkout;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] pair_val(input int p);
    if (p >= cap_q.size()) return 'x;
    return {cap_q[p].snd, cap_q[p].a, cap_q[p].b};
  endfunction

  // 4-bit bus: word k occupies pairs 1+2k and 2+2k (pair 0 is the reset cycle)
  function automatic logic [16:0] word_at(input int idx);
    int p;
    p = 1 + 2 * idx;
    if (p + 1 >= cap_q.size()) return 'x;
    return {cap_q[p].snd, cap_q[p+1].b, cap_q[p+1].a, cap_q[p].b, cap_q[p].a};
  endfunction

  task automatic assert_reset(input logic [1:0] wsel);
    @(negedge clk);
    #1;
    rst = 1'b0;
    WdAvail = 1'b0;
    syncReq = 1'b0;
    width = wsel;
    #1;
    cap_q.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_pairs(input int n, input string tag);
    int guard;
    guard = 0;
    while (cap_q.size() < n && guard < 4000) begin
      @(negedge clk);
      #2;
      guard++;
    end
    check({"pairs_", tag}, 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic push_word(input logic [15:0] w);
    int guard;
    guard = 0;
    @(negedge clk);
    #1;
    while (!WdReady && guard < 500) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("push_ready", 32'(WdReady), 32'd1);
    PacketWd = w;
    WdAvail = 1'b1;
    @(negedge clk);
    #1;
    WdAvail = 1'b0;
    check("ready_fall", 32'(WdReady), 32'd0);
    $display("push word %h", w);
  endtask

  task automatic stream5();
    for (int i = 0; i < 5; i++) push_word(stream_words[i]);
  endtask

  task automatic check_words(input string tag, input int n);
    for (int k = 0; k < n; k++)
      check($sformatf("%s_word%0d", tag, k), 32'(word_at(k)), 32'(exp_w[k]));
  endtask

  initial begin
    vecs[0] = '{2'd3, 16'h7142, 4'd2, 32'h0000_0012, 32'h0000_0074};
    vecs[1] = '{2'd3, 16'h6919, 4'd2, 32'h0000_0099, 32'h0000_0061};
    vecs[2] = '{2'd3, 16'hffff, 4'd2, 32'h0000_00ff, 32'h0000_00ff};
    vecs[3] = '{2'd2, 16'h0042, 4'd4, 32'h0000_0002, 32'h0000_0010};
    vecs[4] = '{2'd2, 16'h1234, 4'd4, 32'h0000_1230, 32'h0000_0001};
    vecs[5] = '{2'd1, 16'h00a5, 4'd8, 32'h0000_0011, 32'h0000_1100};
    vecs[6] = '{2'd0, 16'h8001, 4'd8, 32'h0000_0001, 32'h1000_0000};
    stream_words = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090a};

    // ---- reset values, idle sync at width 3, trace clock period
    assert_reset(2'd3);
    check("rst_douta", 32'(traceDouta), 32'd0);
    check("rst_doutb", 32'(traceDoutb), 32'd0);
    check("rst_tclk", 32'(traceClkout), 32'd0);
    check("rst_ready", 32'(WdReady), 32'd0);
    check("rst_sending", 32'(sending), 32'd0);
    release_reset();
    check("ready_at_release", 32'(WdReady), 32'd0);
    @(negedge clk);
    #1;
    check("ready_after_release", 32'(WdReady), 32'd1);
    wait_pairs(13, "idle");
    check("first_pair_zero", 32'(pair_val(0)), 32'd0);
    for (int p = 1; p < 13; p++) begin
      check($sformatf("idle_pair%0d", p), 32'(pair_val(p)),
            32'({1'b0, 4'hf, (p % 4 == 0) ? 4'h7 : 4'hf}));
      check($sformatf("tclk_period%0d", p), cap_q[p].stamp - cap_q[p-1].stamp, 32'd4);
    end
    $display("idle sync sequence checked");

    // ---- back-to-back words at width 3
    assert_reset(2'd3);
    release_reset();
    push_word(16'h7142);
    push_word(16'h6919);
    wait_pairs(13, "b2b");
    exp_w[0] = SHI; exp_w[1] = SLO; exp_w[2] = {1'b1, 16'h7142};
    exp_w[3] = {1'b1, 16'h6919}; exp_w[4] = SHI; exp_w[5] = SLO;
    check_words("b2b", 6);
    $display("back-to-back 7142 6919 checked");

    // ---- single-word vector table over all widths
    for (int v = 0; v < 7; v++) begin
      int idx;
      int n;
      n = int'(vecs[v].n);
      assert_reset(vecs[v].width);
      release_reset();
      push_word(vecs[v].word);
      wait_pairs(2 + 3 * n, $sformatf("vec%0d", v));
      idx = 0;
      for (int p = 1; p < cap_q.size(); p++) begin
        if (cap_q[p].snd) begin
          if (idx < n) begin
            check($sformatf("vec%0d_pair%0d", v, idx),
                  32'({cap_q[p].a, cap_q[p].b}),
                  32'({vecs[v].a_seq[4*idx +: 4], vecs[v].b_seq[4*idx +: 4]}));
          end
          idx++;
        end
      end
      check($sformatf("vec%0d_count", v), 32'(idx), 32'(n));
      $display("vector %0d width=%0d word=%h checked", v, vecs[v].width, vecs[v].word);
    end

    // ---- periodic sync every 2 words; syncReq during a sync is absorbed
    assert_reset(2'd3);
    release_reset();
    fork
      stream5();
      begin
        wait_pairs(10, "absorb_pulse");
        syncReq = 1'b1;
        @(negedge clk);
        #1;
        syncReq = 1'b0;
      end
    join
    wait_pairs(27, "absorb");
    exp_w = '{SHI, SLO, {1'b1, 16'h0102}, {1'b1, 16'h0304}, SHI, SLO,
              {1'b1, 16'h0506}, {1'b1, 16'h0708}, SHI, SLO,
              {1'b1, 16'h090a}, SHI, SLO};
    check_words("absorb", 13);
    $display("periodic sync with absorbed request checked");

    // ---- syncReq during a data word inserts a sync and restarts the count
    assert_reset(2'd3);
    release_reset();
    fork
      stream5();
      begin
        wait_pairs(6, "req_pulse");
        syncReq = 1'b1;
        @(negedge clk);
        #1;
        syncReq = 1'b0;
      end
    join
    wait_pairs(27, "req");
    exp_w = '{SHI, SLO, {1'b1, 16'h0102}, SHI, SLO, {1'b1, 16'h0304},
              {1'b1, 16'h0506}, SHI, SLO, {1'b1, 16'h0708},
              {1'b1, 16'h090a}, SHI, SLO};
    check_words("req", 13);
    $display("requested sync checked");

    // ---- reset mid-word at width 1
    assert_reset(2'd1);
    release_reset();
    push_word(16'h5a3c);
    wait_pairs(20, "midword");
    check("midword_on_bus", 32'(pair_val(19)), 32'({1'b1, 4'h1, 4'h1}));
    #1;
    rst = 1'b0;
    #1;
    check("async_douta", 32'(traceDouta), 32'd0);
    check("async_doutb", 32'(traceDoutb), 32'd0);
    check("async_tclk", 32'(traceClkout), 32'd0);
    check("async_ready", 32'(WdReady), 32'd0);
    check("async_sending", 32'(sending), 32'd0);
    cap_q.delete();
    release_reset();
    wait_pairs(33, "after_midword");
    check("after_first_zero", 32'(pair_val(0)), 32'd0);
    for (int p = 1; p < 33; p++) begin
      if (p <= 16)
        check($sformatf("after_pair%0d", p), 32'(pair_val(p)),
              32'({1'b0, 4'h1, (p == 16) ? 4'h0 : 4'h1}));
      else
        check($sformatf("after_snd%0d", p), 32'(cap_q[p].snd), 32'd0);
    end
    $display("mid-word reset checked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_tx.md
# trace_tx

Transmit side of the TPIU-style parallel trace port that `traceIF` receives. Accepts 16-bit packet words from an upstream formatter and serialises them, LSB first, onto a 1/2/4-bit DDR trace bus with a generated trace clock. Inserts the 32-bit TPIU sync sequence (bytes ff ff ff 7f) after reset, on request, periodically, and whenever idle. Used as a trace source in testbeds and loopback builds, driving `traceIF` pin-for-pin.

## Interface
- `SYNC_INTERVAL`, 64: data words between forced syncs; 0 disables periodic sync.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `width`  in  2  bus width: 0,1 = 1 bit; 2 = 2 bit; 3 = 4 bit.
- `PacketWd`  in  16  word to send; low byte goes first.
- `WdAvail`  in  1  upstream valid.
- `WdReady`  out  1  registered ready; a word transfers on a cycle with `WdAvail && WdReady`.
- `syncReq`  in  1  single-cycle pulse requesting a sync at the next word boundary.
- `traceDouta`  out  4  data for the trace-clock rising edge.
- `traceDoutb`  out  4  data for the trace-clock falling edge.
- `traceClkout`  out  1  generated trace clock, clk/4.
- `sending`  out  1  high while the word on the bus is a data word, not sync.

## Operation
- 2-bit phase counter `ph` free-runs from reset. `traceClkout` is 0 in ph0 and ph3, and 1 in ph1 and ph2.
- Outputs update only at ph0 entry (a trace cycle). This gives 1 clk of setup before the rise, and B stays stable across the fall.
- Width is latched at each word boundary as w = 1/2/4. A mid-word change of `width` takes effect on the next word.
- Each trace cycle shifts 2w bits out of a 16-bit shift register:
  - A = sr[w-1:0];
  - B = sr[2w-1:w];
  - unused output bits are 0.
- Trace cycles per word are 8, 4 or 2 for w = 1, 2 or 4.
- Holding register of one word:
  - `WdReady` = holding empty;
  - accepted word enters holding on the clock after the transfer;
  - upstream may stream back-to-back.
- Word-boundary selection (last trace cycle of the current word done), in priority order:
  1. a sync is pending: load 16'hffff, then 16'h7fff, as one atomic pair with `sending` = 0;
  2. holding is full: load holding and set `sending` = 1;
  3. otherwise (idle): emit a full sync pair.
- A sync becomes pending when any of these occurs:
  - reset release;
  - a `syncReq` pulse, latched until served;
  - `SYNC_INTERVAL` data words sent since the last sync.
- The word counter clears when any sync completes.
- A `syncReq` that arrives during a sync is absorbed by that sync. No second sync is sent.
- States: SYNC_HI → SYNC_LO → DATA or SYNC_HI; DATA → DATA or SYNC_HI. Reset enters SYNC_HI.

## Timing
- Reset values:
  - `traceClkout` = 0;
  - `traceDouta` = `traceDoutb` = 0;
  - `WdReady` = 0;
  - `sending` = 0;
  - ph = 0;
  - state = SYNC_HI with pending sync.
- The first ph0 after release drives the first 2w bits of 16'hffff.
- `WdReady` rises 1 clk after reset release. It falls the clock after a transfer and rises the clock after holding drains into the shift register.
- Latency from transfer to first bits on the bus: at most one word time plus 4 clk, when no sync intervenes.
- Peak throughput is one word per 8/16/32 clk at 4/2/1-bit width.
- Reset mid-word abandons all state immediately. Outputs return to reset values asynchronously.

## Structure
- Package `trace_pkg` holds:
  - SYNC_HI = 16'hffff and SYNC_LO = 16'h7fff;
  - width encodings;
  - the state enum.
- Sub-module `trace_tx_ser` holds the shift register, latched width, and trace-cycle counter. It signals word-done to the control FSM in `trace_tx`.

## Test plan
- Reset release at width 3, no data → A/B pairs (f,f),(f,f),(f,f),(f,7) repeating; `sending` = 0; `traceClkout` period 4 clk.
- Width 3, words 0x7142 then 0x6919 back-to-back → after sync, pairs (2,4),(1,7),(9,1),(9,6) with no gap; `WdReady` never stalls the stream beyond the holding depth.
- Width 2, word 0x0042 → A/B sequence (2,0),(0,1),(0,0),(0,0); bits [3:2] of both outputs stay 0.
- `SYNC_INTERVAL` = 2, stream of 5 words → sync after words 2 and 4. `syncReq` pulsed during a sync → no extra sync.
- Reset asserted mid-word at width 1 → outputs 0 at once; after release, sync is emitted first and the lost word is not resent.
- Loopback into `traceIF` at widths 1, 2 and 3 sending 0x7142, 0x6919 → receiver asserts `sync`, then presents `PacketWd` 0x7142 and 0x6919 with `WdAvail`.
